fnd_app_scheduler: RTL and testbench
====================================

Name: fnd_app_scheduler

Overview:
- Shares one 4-digit FND and the user buttons among three applications: watch, cook timer and stop watch.
- A mode button cycles the active application.
- Only the active application receives button pulses, and only its BCD value reaches the FND controller.
- A rising cook-timer alarm pre-empts any mode: the scheduler forces a blinking cook display until the alarm is acknowledged or times out, then restores the previous mode.

Parameters:
- BLINK_HALF, 50_000_000, clk cycles per blink half-period (0.5 s at 100 MHz).
- ALARM_HALVES, 60, blink half-periods before the alarm auto-acknowledges (30 s).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mode_btn  in  1  debounced 1-cycle mode pulse (button_cntr pedge)
- btn_in  in  3  debounced 1-cycle application button pulses
- watch_value  in  16  watch BCD {min,sec}
- cook_value  in  16  cook timer BCD {min,sec}
- stop_value  in  16  stop watch BCD {sec,csec}
- cook_alarm  in  1  cook timer alarm level
- watch_btn  out  3  pulses routed to watch
- cook_btn  out  3  pulses routed to cook timer
- stop_btn  out  3  pulses routed to stop watch
- alarm_ack  out  1  1-cycle pulse to cook timer alarm_off
- fnd_value  out  16  value to FND_cntr
- fnd_blank  out  1  1 = FND_cntr must blank all digits
- mode_led  out  4  one-hot {ALARM,STOP,COOK,WATCH}

Behaviour:
- Reset (async, reset_n=0):
  - state=WATCH, saved_mode=WATCH.
  - All *_btn=0, alarm_ack=0, fnd_blank=0, mode_led=4'b0001.
  - Blink counter=0, blink_phase=1, half_cnt=0, alarm_d=0.
- States: WATCH, COOK, STOP, ALARM (2-bit encoding; mode constants live in the package).
- Mode cycling: mode_btn in WATCH/COOK/STOP steps WATCH->COOK->STOP->WATCH on the next edge.
- Routing:
  - In WATCH/COOK/STOP, btn_in is registered to the active application's *_btn with exactly 1-cycle latency.
  - The other *_btn outputs stay 0.
- mode_btn and btn_in in the same cycle: the mode change wins and btn_in is dropped, so no pulse reaches any application.
- fnd_value is a combinational mux on the state register:
  - WATCH -> watch_value
  - COOK -> cook_value
  - STOP -> stop_value
  - ALARM -> cook_value
- Alarm entry:
  - alarm_d registers cook_alarm; a rising edge is cook_alarm=1 with alarm_d=0.
  - From WATCH/COOK/STOP, a rising edge sets saved_mode=current mode and state=ALARM.
  - On entry, blink counter=0, blink_phase=1 and half_cnt=0.
  - A rising edge has priority over mode_btn and btn_in in the same cycle; both are dropped.
- In ALARM:
  - The blink counter counts 0..BLINK_HALF-1. At wrap it toggles blink_phase and increments half_cnt.
  - fnd_blank = ~blink_phase. fnd_blank is 0 in all other states.
  - No *_btn pulses are forwarded.
  - Any btn_in bit or mode_btn triggers alarm_ack for 1 cycle (registered, next edge) and state=saved_mode. The press is consumed.
  - When half_cnt reaches ALARM_HALVES: alarm_ack for 1 cycle, then return to saved_mode.
  - If cook_alarm falls while in ALARM: return to saved_mode with no alarm_ack.
  - If a press and the timeout coincide: only one alarm_ack pulse is issued.
- A cook_alarm level that stays high after return does not re-enter ALARM; re-entry requires a new rising edge.
- mode_led is one-hot per state; in ALARM it is 4'b1000.
- Reset asserted mid-ALARM: immediate return to reset values; no alarm_ack is issued.

Decomposition:
- Package fnd_sched_pkg holds:
  - mode encodings MODE_WATCH=0, MODE_COOK=1, MODE_STOP=2, MODE_ALARM=3;
  - the one-hot LED constants.
- Sub-module blink_timer (BLINK_HALF, ALARM_HALVES) provides:
  - inputs clk, reset_n, clear;
  - outputs phase, expired.
  - Its cycle counter is sized $clog2(BLINK_HALF) and its half-period counter is sized $clog2(ALARM_HALVES+1).

Test Plan (BLINK_HALF=4, ALARM_HALVES=6):
- Reset, then 3 mode_btn pulses spaced 5 cycles: mode_led goes 0001->0010->0100->0001; fnd_value follows watch/cook/stop values 16'h1234/16'h0530/16'h0099.
- In COOK, btn_in=3'b010 pulse: cook_btn=3'b010 exactly 1 cycle later; watch_btn and stop_btn stay 0. The same pulse coinciding with mode_btn: no pulse anywhere and the state advances to STOP.
- In STOP, raise cook_alarm:
  - State goes to ALARM next edge with mode_led=1000 and fnd_value=cook_value.
  - fnd_blank reads 0 for 4 cycles, 1 for 4 cycles, and so on.
  - A btn_in pulse gives alarm_ack=1 for one cycle and a return to STOP, with stop_btn staying 0.
- Raise cook_alarm and hold with no press: alarm_ack pulses once after 24 cycles in ALARM; the block returns to the saved mode and does not re-enter ALARM while cook_alarm stays 1.
- In ALARM, drop cook_alarm after 5 cycles: return to saved mode, alarm_ack never asserts, fnd_blank=0.
- Assert reset_n=0 asynchronously mid-ALARM (between edges): all outputs go to reset values immediately; after release the state is WATCH and fnd_blank=0.

Source files
------------

// File: rtl/fnd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fnd_sched_pkg
// Purpose  : Mode encodings, mode LED patterns and mode helpers for the
//            FND application scheduler.
// Revision : 1.0
// ============================================================================
package fnd_sched_pkg;

    typedef enum logic [1:0] {
        MODE_WATCH = 2'd0,
        MODE_COOK  = 2'd1,
        MODE_STOP  = 2'd2,
        MODE_ALARM = 2'd3
    } mode_e;

    localparam logic [3:0] c_LED_WATCH = 4'b0001;
    localparam logic [3:0] c_LED_COOK  = 4'b0010;
    localparam logic [3:0] c_LED_STOP  = 4'b0100;
    localparam logic [3:0] c_LED_ALARM = 4'b1000;

    function automatic logic [3:0] mode_to_led(input mode_e mode);
        logic [3:0] led;
        case (mode)
            MODE_WATCH: led = c_LED_WATCH;
            MODE_COOK:  led = c_LED_COOK;
            MODE_STOP:  led = c_LED_STOP;
            default:    led = c_LED_ALARM;
        endcase
        return led;
    endfunction

    // Application rotation order for the mode button; ALARM is never a target.
    function automatic mode_e next_app(input mode_e mode);
        mode_e nxt;
        case (mode)
            MODE_WATCH: nxt = MODE_COOK;
            MODE_COOK:  nxt = MODE_STOP;
            default:    nxt = MODE_WATCH;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blink_timer.sv
`default_nettype none
// ============================================================================
// Module   : blink_timer
// Purpose  : Blink phase generator with an alarm timeout after a fixed number
//            of blink half-periods.
// Revision : 1.0
// ============================================================================
module blink_timer #(
    parameter int BLINK_HALF   = 50_000_000,
    parameter int ALARM_HALVES = 60
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic phase,
    output logic expired
);

    localparam int CNT_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int HALF_W = $clog2(ALARM_HALVES + 1);
    localparam logic [CNT_W-1:0]  c_CNT_LAST  = CNT_W'(BLINK_HALF - 1);
    localparam logic [HALF_W-1:0] c_HALF_LAST = HALF_W'(ALARM_HALVES - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [HALF_W-1:0] r_half_cnt;
    logic              r_phase;
    logic              w_wrap;

    assign w_wrap = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_half_cnt <= '0;
            r_phase    <= 1'b1;
        end else if (clear) begin
            r_cnt      <= '0;
            r_half_cnt <= '0;
            r_phase    <= 1'b1;
        end else if (w_wrap) begin
            r_cnt      <= '0;
            r_phase    <= ~r_phase;
            r_half_cnt <= r_half_cnt + HALF_W'(1);
        end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
        end
    end

    assign phase = r_phase;
    // Fires on the wrap that completes the last half-period, so the
    // acknowledge lands exactly when half_cnt reaches ALARM_HALVES.
    assign expired = w_wrap && (r_half_cnt == c_HALF_LAST) && !clear;

endmodule
`default_nettype wire

// File: rtl/fnd_app_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fnd_app_scheduler
// Purpose  : Shares one 4-digit FND and the user buttons among watch, cook
//            timer and stop watch; a cook alarm pre-empts with a blinking display.
// Revision : 1.0
// ============================================================================
module fnd_app_scheduler
    import fnd_sched_pkg::*;
#(
    parameter int BLINK_HALF   = 50_000_000,
    parameter int ALARM_HALVES = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mode_btn,
    input  logic [2:0]  btn_in,
    input  logic [15:0] watch_value,
    input  logic [15:0] cook_value,
    input  logic [15:0] stop_value,
    input  logic        cook_alarm,
    output logic [2:0]  watch_btn,
    output logic [2:0]  cook_btn,
    output logic [2:0]  stop_btn,
    output logic        alarm_ack,
    output logic [15:0] fnd_value,
    output logic        fnd_blank,
    output logic [3:0]  mode_led
);

    mode_e      r_state, w_state_nxt;
    mode_e      r_saved_mode, w_saved_nxt;
    logic       r_alarm_d;
    logic [2:0] r_watch_btn, r_cook_btn, r_stop_btn;
    logic [2:0] w_watch_nxt, w_cook_nxt, w_stop_nxt;
    logic       r_alarm_ack, w_ack_nxt;
    logic       w_alarm_rise, w_press;
    logic       w_blink_clear, w_blink_phase, w_expired;

    assign w_alarm_rise  = cook_alarm & ~r_alarm_d;
    assign w_press       = mode_btn | (|btn_in);
    assign w_blink_clear = (r_state != MODE_ALARM);

    blink_timer #(
        .BLINK_HALF   (BLINK_HALF),
        .ALARM_HALVES (ALARM_HALVES)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_blink_clear),
        .phase   (w_blink_phase),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= MODE_WATCH;
            r_saved_mode <= MODE_WATCH;
            r_alarm_d    <= 1'b0;
            r_watch_btn  <= 3'b000;
            r_cook_btn   <= 3'b000;
            r_stop_btn   <= 3'b000;
            r_alarm_ack  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_saved_mode <= w_saved_nxt;
            r_alarm_d    <= cook_alarm;
            r_watch_btn  <= w_watch_nxt;
            r_cook_btn   <= w_cook_nxt;
            r_stop_btn   <= w_stop_nxt;
            r_alarm_ack  <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved_mode;
        w_watch_nxt = 3'b000;
        w_cook_nxt  = 3'b000;
        w_stop_nxt  = 3'b000;
        w_ack_nxt   = 1'b0;
        case (r_state)
            MODE_ALARM: begin
                // A press and a timeout together still yield a single ack.
                if (w_press || w_expired) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = r_saved_mode;
                end else if (!cook_alarm) begin
                    w_state_nxt = r_saved_mode;
                end
            end
            default: begin
                if (w_alarm_rise) begin
                    w_saved_nxt = r_state;
                    w_state_nxt = MODE_ALARM;
                end else if (mode_btn) begin
                    w_state_nxt = next_app(r_state);
                end else begin
                    case (r_state)
                        MODE_WATCH: w_watch_nxt = btn_in;
                        MODE_COOK:  w_cook_nxt  = btn_in;
                        MODE_STOP:  w_stop_nxt  = btn_in;
                        default:    ;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        fnd_value = cook_value;
        case (r_state)
            MODE_WATCH: fnd_value = watch_value;
            MODE_STOP:  fnd_value = stop_value;
            default:    fnd_value = cook_value;
        endcase
    end

    assign fnd_blank = (r_state == MODE_ALARM) & ~w_blink_phase;
    assign mode_led  = mode_to_led(r_state);
    assign watch_btn = r_watch_btn;
    assign cook_btn  = r_cook_btn;
    assign stop_btn  = r_stop_btn;
    assign alarm_ack = r_alarm_ack;

endmodule
`default_nettype wire

// File: tb/tb_fnd_app_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_app_scheduler
// Purpose  : Directed self-checking bench for fnd_app_scheduler.
// Revision : 1.0
// ============================================================================
module tb_fnd_app_scheduler;

    localparam int BLINK_HALF   = 4;
    localparam int ALARM_HALVES = 6;

    localparam logic [15:0] c_WATCH_VAL = 16'h1234;
    localparam logic [15:0] c_COOK_VAL  = 16'h0530;
    localparam logic [15:0] c_STOP_VAL  = 16'h0099;

    logic        clk;
    logic        reset_n;
    logic        mode_btn;
    logic [2:0]  btn_in;
    logic [15:0] watch_value, cook_value, stop_value;
    logic        cook_alarm;
    logic [2:0]  watch_btn, cook_btn, stop_btn;
    logic        alarm_ack;
    logic [15:0] fnd_value;
    logic        fnd_blank;
    logic [3:0]  mode_led;

    int n_checks;
    int n_fail;

    fnd_app_scheduler #(
        .BLINK_HALF   (BLINK_HALF),
        .ALARM_HALVES (ALARM_HALVES)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode_btn    (mode_btn),
        .btn_in      (btn_in),
        .watch_value (watch_value),
        .cook_value  (cook_value),
        .stop_value  (stop_value),
        .cook_alarm  (cook_alarm),
        .watch_btn   (watch_btn),
        .cook_btn    (cook_btn),
        .stop_btn    (stop_btn),
        .alarm_ack   (alarm_ack),
        .fnd_value   (fnd_value),
        .fnd_blank   (fnd_blank),
        .mode_led    (mode_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mode_pulse();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ack_cnt;
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        mode_btn    = 1'b0;
        btn_in      = 3'b000;
        watch_value = c_WATCH_VAL;
        cook_value  = c_COOK_VAL;
        stop_value  = c_STOP_VAL;
        cook_alarm  = 1'b0;

        // Reset state
        #12;
        check("rst_led",   mode_led, 4'b0001);
        check("rst_fnd",   fnd_value, c_WATCH_VAL);
        check("rst_blank", fnd_blank, 1'b0);
        check("rst_ack",   alarm_ack, 1'b0);
        check("rst_btns",  {watch_btn, cook_btn, stop_btn}, 9'd0);
        step();
        reset_n = 1'b1;
        step();

        // Mode cycling
        mode_pulse();
        check("cyc_led_cook", mode_led, 4'b0010);
        check("cyc_fnd_cook", fnd_value, c_COOK_VAL);
        step_n(4);
        mode_pulse();
        check("cyc_led_stop", mode_led, 4'b0100);
        check("cyc_fnd_stop", fnd_value, c_STOP_VAL);
        step_n(4);
        mode_pulse();
        check("cyc_led_watch", mode_led, 4'b0001);
        check("cyc_fnd_watch", fnd_value, c_WATCH_VAL);
        step_n(4);

        // Routing in COOK
        mode_pulse();
        step();
        btn_in = 3'b010;
        step();
        btn_in = 3'b000;
        check("route_cook",  cook_btn, 3'b010);
        check("route_watch", watch_btn, 3'b000);
        check("route_stop",  stop_btn, 3'b000);
        step();
        check("route_cook_1cyc", cook_btn, 3'b000);

        // mode_btn wins over btn_in
        btn_in   = 3'b010;
        mode_btn = 1'b1;
        step();
        btn_in   = 3'b000;
        mode_btn = 1'b0;
        check("coll_led", mode_led, 4'b0100);
        check("coll_btns", {watch_btn, cook_btn, stop_btn}, 9'd0);
        step();
        check("coll_btns_later", {watch_btn, cook_btn, stop_btn}, 9'd0);

        // Alarm entry from STOP and blink pattern
        cook_alarm = 1'b1;
        step();
        check("alm_led", mode_led, 4'b1000);
        check("alm_fnd", fnd_value, c_COOK_VAL);
        for (int k = 0; k < 12; k++) begin
            if (k != 0) step();
            check($sformatf("alm_blank_%0d", k), fnd_blank, ((k / 4) % 2 == 1) ? 1'b1 : 1'b0);
        end
        btn_in = 3'b001;
        step();
        btn_in = 3'b000;
        check("ack_press",       alarm_ack, 1'b1);
        check("ack_press_led",   mode_led, 4'b0100);
        check("ack_press_stop",  stop_btn, 3'b000);
        check("ack_press_blank", fnd_blank, 1'b0);
        step();
        check("ack_press_1cyc",  alarm_ack, 1'b0);
        check("no_reenter_led",  mode_led, 4'b0100);

        // Timeout with cook_alarm held
        cook_alarm = 1'b0;
        step();
        cook_alarm = 1'b1;
        step();
        check("to_entry_led", mode_led, 4'b1000);
        n = 0;
        while (alarm_ack !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("to_cycles", n, 24);
        check("to_led", mode_led, 4'b0100);
        ack_cnt = (alarm_ack === 1'b1) ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (alarm_ack === 1'b1) ack_cnt++;
        end
        check("to_ack_once", ack_cnt, 1);
        check("to_no_reenter", mode_led, 4'b0100);

        // Alarm dropped after 5 cycles; saved mode is WATCH
        cook_alarm = 1'b0;
        mode_pulse();
        check("drop_pre_led", mode_led, 4'b0001);
        cook_alarm = 1'b1;
        step();
        check("drop_entry_led", mode_led, 4'b1000);
        ack_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (alarm_ack === 1'b1) ack_cnt++;
        end
        cook_alarm = 1'b0;
        step();
        if (alarm_ack === 1'b1) ack_cnt++;
        check("drop_led",   mode_led, 4'b0001);
        check("drop_fnd",   fnd_value, c_WATCH_VAL);
        check("drop_blank", fnd_blank, 1'b0);
        step();
        if (alarm_ack === 1'b1) ack_cnt++;
        check("drop_no_ack", ack_cnt, 0);

        // Alarm rise beats mode_btn and btn_in, then async reset mid-ALARM
        mode_pulse();
        step();
        cook_alarm = 1'b1;
        mode_btn   = 1'b1;
        btn_in     = 3'b001;
        step();
        mode_btn   = 1'b0;
        btn_in     = 3'b000;
        check("prio_led",  mode_led, 4'b1000);
        check("prio_btns", {watch_btn, cook_btn, stop_btn}, 9'd0);
        check("prio_ack",  alarm_ack, 1'b0);
        step_n(5);
        check("prio_blank_on", fnd_blank, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_led",   mode_led, 4'b0001);
        check("arst_blank", fnd_blank, 1'b0);
        check("arst_fnd",   fnd_value, c_WATCH_VAL);
        check("arst_ack",   alarm_ack, 1'b0);
        cook_alarm = 1'b0;
        step();
        reset_n = 1'b1;
        step_n(2);
        check("post_rst_led",   mode_led, 4'b0001);
        check("post_rst_blank", fnd_blank, 1'b0);
        check("post_rst_ack",   alarm_ack, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
